// File: rtl/ws2812_rx_decoder.sv
// WS2812b NRZ receiver: measures high-pulse widths, rebuilds 24-bit GRB pixels, and detects the latch gap.
// Optional line forwarding is enabled by defining WS2812_FWD_EN.
module ws2812_rx_decoder #(
    parameter int T_THRESH   = 60,
    parameter int T_MIN_HIGH = 10,
    parameter int T_MAX_HIGH = 150,
    parameter int T_RESET    = 5000,
    parameter int IDX_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_din,
    output logic [23:0]      o_pixel,
    output logic             o_pixel_valid,
    output logic [IDX_W-1:0] o_pixel_idx,
    output logic             o_frame_end,
    output logic             o_err,
    output logic             o_dout
);

    localparam int CNT_W = $clog2(T_RESET + 1);
    localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_THRESH   = CNT_W'(T_THRESH);
    localparam logic [CNT_W-1:0] L_MIN_HIGH = CNT_W'(T_MIN_HIGH);
    localparam logic [CNT_W-1:0] L_MAX_M1   = CNT_W'(T_MAX_HIGH - 1);
    localparam logic [CNT_W-1:0] L_RESET_M1 = CNT_W'(T_RESET - 1);

    typedef enum logic [1:0] {
        S_SYNC  = 2'd0,
        S_READY = 2'd1,
        S_HIGH  = 2'd2,
        S_LOW   = 2'd3
    } state_t;

    logic             r_sync1, r_sync2, r_prev, r_rise, r_fall;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_bit_cnt;
    logic [22:0]      r_shift;
    logic [IDX_W-1:0] r_idx;

    // Both edge strobes are registered so rising and falling edges share the same latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_din;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_rise  <= r_sync2 & ~r_prev;
            r_fall  <= ~r_sync2 & r_prev;
        end
    end

    logic        w_bit;
    logic [23:0] w_shift;
    logic        w_high_err;

    assign w_bit      = (r_cnt >= L_THRESH);
    assign w_shift    = {r_shift, w_bit};
    assign w_high_err = r_fall ? (r_cnt < L_MIN_HIGH) : (r_cnt >= L_MAX_M1);

`ifdef WS2812_FWD_EN
    logic r_fwd_gate;
    assign o_dout = r_sync2 & r_fwd_gate;
`else
    assign o_dout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_SYNC;
            r_cnt         <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_idx         <= '0;
            o_pixel       <= '0;
            o_pixel_valid <= 1'b0;
            o_pixel_idx   <= '0;
            o_frame_end   <= 1'b0;
            o_err         <= 1'b0;
`ifdef WS2812_FWD_EN
            r_fwd_gate    <= 1'b0;
`endif
        end else begin
            // NOTE: strobes default low here so each event pulses for exactly one cycle.
            o_pixel_valid <= 1'b0;
            o_frame_end   <= 1'b0;
            o_err         <= 1'b0;
            case (r_state)
                S_SYNC: begin
                    if (r_prev) begin
                        r_cnt <= '0;
                    end else if (r_cnt >= L_RESET_M1) begin
                        r_state   <= S_READY;
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
                        r_idx     <= '0;
                    end else begin
                        r_cnt <= r_cnt + L_ONE;
                    end
                end
                S_READY: begin
                    if (r_rise) begin
                        r_state <= S_HIGH;
                        r_cnt   <= L_ONE;
                    end
                end
                S_HIGH: begin
                    if (w_high_err) begin
                        o_err     <= 1'b1;
                        r_state   <= S_SYNC;
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
`ifdef WS2812_FWD_EN
                        r_fwd_gate <= 1'b0;
`endif
                    end else if (r_fall) begin
                        r_state <= S_LOW;
                        r_cnt   <= L_ONE;
                        if (r_bit_cnt == 5'd23) begin
                            o_pixel       <= w_shift;
                            o_pixel_valid <= 1'b1;
                            o_pixel_idx   <= r_idx;
                            r_bit_cnt     <= '0;
                            if (r_idx != '1) r_idx <= r_idx + IDX_W'(1);
`ifdef WS2812_FWD_EN
                            if (r_idx == '0) r_fwd_gate <= 1'b1;
`endif
                        end else begin
                            r_shift   <= w_shift[22:0];
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + L_ONE;
                    end
                end
                S_LOW: begin
                    if (r_rise) begin
                        r_state <= S_HIGH;
                        r_cnt   <= L_ONE;
                    end else if (r_cnt >= L_RESET_M1) begin
                        // LOW is only reachable after a decoded bit, so a frame has always started here.
                        o_frame_end <= 1'b1;
                        o_err       <= (r_bit_cnt != 5'd0);
                        r_state     <= S_READY;
                        r_cnt       <= '0;
                        r_bit_cnt   <= '0;
                        r_idx       <= '0;
`ifdef WS2812_FWD_EN
                        r_fwd_gate  <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + L_ONE;
                    end
                end
                default: r_state <= S_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Scoreboard bench for ws2812_rx_decoder: a driver builds line waveforms and queues expected events,
// a monitor pops and compares whenever the DUT strobes. Define WS2812_FWD_EN to also check forwarding.
`timescale 1ns/1ps
module tb_ws2812_rx_decoder;

    localparam int T_THRESH   = 60;
    localparam int T_MIN_HIGH = 10;
    localparam int T_MAX_HIGH = 150;
    localparam int T_RESET    = 5000;
    localparam int IDX_W      = 8;
    localparam int GAP        = T_RESET + 50;
    localparam int IDX_MAX    = (1 << IDX_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             din = 1'b0;
    logic [23:0]      o_pixel;
    logic             o_pixel_valid;
    logic [IDX_W-1:0] o_pixel_idx;
    logic             o_frame_end;
    logic             o_err;
    logic             o_dout;

    ws2812_rx_decoder #(
        .T_THRESH  (T_THRESH),
        .T_MIN_HIGH(T_MIN_HIGH),
        .T_MAX_HIGH(T_MAX_HIGH),
        .T_RESET   (T_RESET),
        .IDX_W     (IDX_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_din        (din),
        .o_pixel      (o_pixel),
        .o_pixel_valid(o_pixel_valid),
        .o_pixel_idx  (o_pixel_idx),
        .o_frame_end  (o_frame_end),
        .o_err        (o_err),
        .o_dout       (o_dout)
    );

    always #5 clk = ~clk;

    typedef enum int { EV_PIX, EV_FE, EV_ERR } ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [23:0] px;
        int          idx;
        logic        fe_err;
        int          cyc;
    } ev_t;

    ev_t  q[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   m_idx = 0;
    int   dout_bad = 0;
    logic h1 = 1'b0;
    logic h2 = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        h1  <= din;
        h2  <= h1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input ev_kind_t k, input logic [23:0] px, input int idx, input logic fe_err, input int c);
        ev_t e;
        e.kind = k; e.px = px; e.idx = idx; e.fe_err = fe_err; e.cyc = c;
        q.push_back(e);
    endtask

    // Reference: a high width decodes as 1 when >= T_THRESH; the 24th bit completes a pixel,
    // reported 4 clock edges after the line is driven low (1 sample + 3 cycles of latency).
    task automatic send_widths(input int hw[24], input int lw[24], input logic expect_pix);
        logic [23:0] px = '0;
        for (int i = 0; i < 24; i++) px = {px[22:0], (hw[i] >= T_THRESH)};
        for (int i = 0; i < 24; i++) begin
            din = 1'b1;
            repeat (hw[i]) @(negedge clk);
            din = 1'b0;
            if (i == 23 && expect_pix) begin
                push_ev(EV_PIX, px, m_idx, 1'b0, cyc + 4);
                m_idx = (m_idx == IDX_MAX) ? IDX_MAX : m_idx + 1;
            end
            repeat (lw[i]) @(negedge clk);
        end
    endtask

    task automatic send_pixel(input logic [23:0] px, input logic expect_pix);
        int hw[24];
        int lw[24];
        for (int i = 0; i < 24; i++) begin
            hw[i] = px[23-i] ? int'($urandom_range(T_THRESH, 120)) : int'($urandom_range(T_MIN_HIGH, T_THRESH - 1));
            lw[i] = int'($urandom_range(10, 40));
        end
        send_widths(hw, lw, expect_pix);
    endtask

    task automatic send_fixed(input logic [23:0] px);
        int hw[24];
        int lw[24];
        for (int i = 0; i < 24; i++) begin
            hw[i] = px[23-i] ? 80 : 40;
            lw[i] = px[23-i] ? 45 : 85;
        end
        send_widths(hw, lw, 1'b1);
    endtask

    task automatic send_boundary();
        int hw[24];
        int lw[24];
        for (int i = 0; i < 24; i++) begin
            hw[i] = int'($urandom_range(T_MIN_HIGH, 120));
            lw[i] = int'($urandom_range(10, 40));
        end
        hw[0] = T_MIN_HIGH;
        hw[1] = T_MAX_HIGH - 1;
        hw[3] = T_THRESH - 1;
        hw[4] = T_THRESH;
        send_widths(hw, lw, 1'b1);
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            din = 1'b1;
            repeat ($urandom_range(T_MIN_HIGH, 120)) @(negedge clk);
            din = 1'b0;
            repeat ($urandom_range(10, 40)) @(negedge clk);
        end
    endtask

    task automatic gap(input int n, input logic expect_fe, input logic partial);
        if (expect_fe) push_ev(EV_FE, 24'h0, 0, partial, 0);
        m_idx = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pixel"}, 32'(o_pixel), 32'd0);
        check({tag, "_valid"}, 32'(o_pixel_valid), 32'd0);
        check({tag, "_idx"}, 32'(o_pixel_idx), 32'd0);
        check({tag, "_frame_end"}, 32'(o_frame_end), 32'd0);
        check({tag, "_err"}, 32'(o_err), 32'd0);
        check({tag, "_dout"}, 32'(o_dout), 32'd0);
    endtask

    // Monitor: pops one expectation per DUT strobe cycle and tracks the forwarding gate.
    initial begin
        ev_t        e;
        logic [2:0] flags;
        logic [2:0] exp_flags;
        logic       m_gate;
        logic       exp_dout;
        m_gate = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_gate = 1'b0;
            end else begin
                flags = {o_pixel_valid, o_frame_end, o_err};
                if (flags != 3'b000) begin
                    if (q.size() == 0) begin
                        check("unexpected_event", {29'd0, flags}, 32'd0);
                    end else begin
                        e = q.pop_front();
                        case (e.kind)
                            EV_PIX:  exp_flags = 3'b100;
                            EV_FE:   exp_flags = {2'b01, e.fe_err};
                            default: exp_flags = 3'b001;
                        endcase
                        check("event_flags", {29'd0, flags}, {29'd0, exp_flags});
                        if (e.kind == EV_PIX) begin
                            check("pixel", 32'(o_pixel), 32'(e.px));
                            check("pixel_idx", 32'(o_pixel_idx), e.idx);
                            check("pixel_latency", cyc, e.cyc);
                            if (e.idx == 0) m_gate = 1'b1;
                        end else begin
                            m_gate = 1'b0;
                        end
                    end
                end
`ifdef WS2812_FWD_EN
                exp_dout = h2 & m_gate;
`else
                exp_dout = 1'b0;
`endif
                if (o_dout !== exp_dout) dout_bad++;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, %0d events still pending", q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        din   = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Pulses before the first reset gap are ignored, then a fixed-width pixel decodes.
        repeat (1000) @(negedge clk);
        send_pixel(24'($urandom), 1'b0);
        gap(GAP, 1'b0, 1'b0);
        send_fixed(24'hFF0055);
        gap(GAP, 1'b1, 1'b0);

        // Multi-pixel frame, 60 us latch, then index restarts with a width-boundary pixel.
        send_pixel(24'h123456, 1'b1);
        send_pixel(24'hABCDEF, 1'b1);
        send_pixel(24'h000001, 1'b1);
        gap(6000, 1'b1, 1'b0);
        send_pixel(24'($urandom), 1'b1);
        send_boundary();
        gap(GAP, 1'b1, 1'b0);

        // Glitch error, ignored pixel while resynchronising, then stuck-high error.
        send_bits(3);
        din = 1'b1;
        repeat (T_MIN_HIGH - 1) @(negedge clk);
        din = 1'b0;
        push_ev(EV_ERR, 24'h0, 0, 1'b0, 0);
        m_idx = 0;
        repeat (50) @(negedge clk);
        send_pixel(24'($urandom), 1'b0);
        gap(GAP, 1'b0, 1'b0);
        send_pixel(24'($urandom), 1'b1);
        send_bits(3);
        din = 1'b1;
        push_ev(EV_ERR, 24'h0, 0, 1'b0, 0);
        m_idx = 0;
        repeat (T_MAX_HIGH + 50) @(negedge clk);
        din = 1'b0;
        gap(GAP, 1'b0, 1'b0);

        // Partial pixel at the latch gap.
        send_bits(12);
        gap(GAP, 1'b1, 1'b1);

        // Reset in the middle of a pixel, then a clean decode.
        send_bits(10);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        m_idx = 0;
        gap(GAP, 1'b0, 1'b0);
        send_pixel(24'h00FF00, 1'b1);
        gap(GAP, 1'b1, 1'b0);

        repeat (20) @(negedge clk);
        check("pending_events", q.size(), 32'd0);
        check("dout_mismatch_cycles", dout_bad, 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ws2812_rx_decoder.md
Name: ws2812_rx_decoder

Overview:
- Receive side of the WS2812b single-wire NRZ link that the colour mux and serializer path drives.
- Samples the serial line, measures high-pulse widths, and reassembles 24-bit GRB pixel words.
- Flags each pixel with its index in the frame and detects the latch/reset gap.
- Used for FPGA loopback self-check of the LED transmit path, and as a regenerating front end for chained strips.

Parameters:
- T_THRESH, 60: high-width threshold in i_clk cycles (100 MHz: 0.6 us); width >= T_THRESH decodes as 1, otherwise 0.
- T_MIN_HIGH, 10: high widths below this are glitches and flag an error.
- T_MAX_HIGH, 150: a high width reaching this count is a stuck-high error.
- T_RESET, 5000: low cycles that constitute a latch/reset gap (50 us).
- IDX_W, 8: width of the pixel index.

Ports:
- i_clk  in  1  system clock, 100 MHz.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_din  in  1  serial WS2812 line, asynchronous to i_clk.
- o_pixel  out  24  last decoded pixel; bit 23 is the first bit received (G7).
- o_pixel_valid  out  1  one-cycle strobe; o_pixel and o_pixel_idx are valid.
- o_pixel_idx  out  IDX_W  0-based pixel position in the current frame; saturates at all-ones.
- o_frame_end  out  1  one-cycle strobe on reset-gap detection.
- o_err  out  1  one-cycle strobe on a timing or framing error.
- o_dout  out  1  forwarded line; see Optional Feature.

Behaviour:
- Clocking and reset:
  - One clock domain; reset is asynchronous and active-low.
  - While i_rst_n = 0, all outputs and counters are 0 and the state is SYNC.
- Input path:
  - i_din passes through a 2-FF synchronizer, then an edge detector.
  - Both edges see identical latency, so measured widths equal line widths ±1 cycle.
- State machine:
  - SYNC: count consecutive low cycles; any high clears the count. The count reaching T_RESET goes to READY without pulsing o_frame_end. All pulses before this point are ignored.
  - READY: line low, bit count 0, pixel index 0. Rising edge goes to HIGH.
  - HIGH: increment the high counter.
    - On a falling edge, classify the width: < T_MIN_HIGH gives error; < T_THRESH gives bit 0; otherwise bit 1. The bit is shifted in MSB-first. Go to LOW.
    - The counter reaching T_MAX_HIGH gives error.
  - LOW: increment the low counter.
    - Rising edge goes to HIGH; low widths from 1 to T_RESET-1 are all accepted.
    - The counter reaching T_RESET gives frame end, then READY.
  - Error, from any state: pulse o_err, discard the partial pixel, go to SYNC.
- Pixel completion:
  - The 24th shifted bit loads o_pixel, pulses o_pixel_valid and presents o_pixel_idx.
  - Index then increments, saturating; bit count clears.
  - o_pixel_valid rises exactly 3 i_clk cycles after the first clock edge that samples i_din low at the end of the 24th bit.
  - o_pixel holds its value until the next completion.
- Frame end:
  - Pulse o_frame_end only if at least one bit was received since READY.
  - If the bit count is nonzero (partial pixel), o_err pulses in the same cycle and the partial pixel is dropped.
  - Index returns to 0.
- Simultaneous events: a pixel completion and an error cannot coincide; completion only occurs on a falling edge inside the legal width window.
- Counters saturate at their limits and never wrap.

Optional Feature:
- Macro: WS2812_FWD_EN.
- Defined:
  - o_dout mirrors synchronized i_din (2-cycle delay), gated low until pixel 0 of the current frame has completed.
  - The gate closes again at frame end, error or reset.
  - This emulates a WS2812 consuming its own pixel.
- Undefined: o_dout is constant 0 and the forwarding logic is absent.

Test Plan:
1. Reset hold, then release; send a valid pixel at cycle 1000 after release -> no o_pixel_valid. Hold low 5000 cycles, then send 0xFF0055 (bit 1 = 80 high/45 low, bit 0 = 40/85) -> o_pixel = 0xFF0055, o_pixel_valid high exactly one cycle, idx 0.
2. Pixels 0x123456, 0xABCDEF, 0x000001, then 60 us low -> three strobes with idx 0, 1, 2, then one o_frame_end pulse. The next frame's first pixel reports idx 0.
3. Width boundaries:
   - high 59 -> bit 0;
   - high 60 -> bit 1;
   - high 9 -> o_err, SYNC, next pixel ignored until a 5000-cycle gap;
   - high held 150 -> o_err.
4. 12 bits, then reset gap -> o_err and o_frame_end in the same cycle, no o_pixel_valid.
5. Assert i_rst_n low after bit 10 of a pixel -> all outputs 0 within the reset. After release plus a gap, 0x00FF00 decodes cleanly.
6. WS2812_FWD_EN defined, two pixels sent -> o_dout stays 0 through pixel 0, then reproduces pixel 1's waveform delayed 2 cycles, and returns to 0 at frame end.
